// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared types and constants for the multi-word add/subtract sequencer
package rca_pkg;

  // Width of one ripple-carry slice; operands are processed one slice per clock
  localparam int SLICE_W = 8;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice-index width: clog2 of the slice count, never narrower than one bit
  function automatic int idx_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/add8_ci.sv
// rtl/add8_ci.sv - combinational 8-bit ripple-carry adder with carry-in
module add8_ci
  import rca_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_ci,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_co
);

  logic [SLICE_W:0] w_c;

  assign w_c[0] = i_ci;

  // One full adder per bit, carry rippling from bit 0 upward
  for (genvar g = 0; g < SLICE_W; g++) begin : g_fa
    assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_co = w_c[SLICE_W];

endmodule

// File: rtl/rca_mw_seq.sv
// rtl/rca_mw_seq.sv - multi-word add/subtract sequencer reusing one 8-bit adder slice
module rca_mw_seq
  import rca_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sub,
  input  logic [SLICE_W*NWORDS-1:0] in_a,
  input  logic [SLICE_W*NWORDS-1:0] in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SLICE_W*NWORDS:0]   out_sum,
  output logic                      busy
);

  localparam int W  = SLICE_W * NWORDS;
  localparam int IW = idx_w(NWORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  state_t              r_state;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic [W:0]          r_sum;
  logic [IW-1:0]       r_idx;
  logic                r_carry;

  logic [SLICE_W-1:0]  w_a_sl;
  logic [SLICE_W-1:0]  w_b_sl;
  logic [SLICE_W-1:0]  w_s;
  logic                w_co;

  // Pick the operand slices addressed by the current slice index
  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (r_idx == IW'(k)) begin
        w_a_sl = r_a[SLICE_W*k +: SLICE_W];
        w_b_sl = r_b[SLICE_W*k +: SLICE_W];
      end
    end
  end

  add8_ci u_add8_ci (
    .i_a   (w_a_sl),
    .i_b   (w_b_sl),
    .i_ci  (r_carry),
    .o_sum (w_s),
    .o_co  (w_co)
  );

  // Sequencer: accept operands, walk the slices with a registered carry, hold result until taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            // Subtract is a + ~b + 1, so the inversion happens once here and the carry seeds the +1
            r_a        <= in_a;
            r_b        <= in_sub ? ~in_b : in_b;
            r_carry    <= in_sub;
            r_idx      <= '0;
            r_sum      <= '0;
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          for (int k = 0; k < NWORDS; k++) begin
            if (r_idx == IW'(k)) r_sum[SLICE_W*k +: SLICE_W] <= w_s;
          end
          r_carry <= w_co;
          if (r_idx == LAST_IDX) begin
            // Index stays on the last slice so it never exceeds NWORDS-1
            r_sum[W]    <= w_co;
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_sum   = r_sum;

endmodule

// File: tb/tb_rca_mw_seq.sv
// tb/tb_rca_mw_seq.sv - self-checking bench for rca_mw_seq at NWORDS=4 and NWORDS=1
module tb_rca_mw_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst4, iv4, sub4, or4, ir4, ov4, bz4;
  logic [31:0] a4, b4;
  logic [32:0] os4;
  logic        rst1, iv1, sub1, or1, ir1, ov1, bz1;
  logic [7:0]  a1, b1;
  logic [8:0]  os1;

  rca_mw_seq #(.NWORDS(4)) u_dut4 (
    .clk(clk), .reset(rst4), .in_valid(iv4), .in_ready(ir4), .in_sub(sub4),
    .in_a(a4), .in_b(b4), .out_valid(ov4), .out_ready(or4), .out_sum(os4), .busy(bz4)
  );

  rca_mw_seq #(.NWORDS(1)) u_dut1 (
    .clk(clk), .reset(rst1), .in_valid(iv1), .in_ready(ir1), .in_sub(sub1),
    .in_a(a1), .in_b(b1), .out_valid(ov1), .out_ready(or1), .out_sum(os1), .busy(bz1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // Reference: plain W-bit arithmetic; top bit is carry for add, "no borrow" for subtract
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic sub, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    a = a & m;
    b = b & m;
    if (!sub) return a + b;
    return ((a >= b) ? (64'd1 << w) : 64'd0) | ((a - b) & m);
  endfunction

  // Scoreboard for the NWORDS=4 instance
  logic [63:0] q4[$];
  longint      d4[$];
  logic        ov4_d = 1'b0;
  int          res4 = 0;
  always @(negedge clk) begin
    if (rst4) begin
      chk("rst4_in_ready", ir4, 1);
      chk("rst4_out_valid", ov4, 0);
      chk("rst4_busy", bz4, 0);
      chk("rst4_out_sum", os4, 0);
      q4.delete();
      d4.delete();
      ov4_d <= 1'b0;
    end else begin
      chk("ready4_vs_busy", ir4, !bz4);
      if (ov4) begin
        chk("busy4_in_done", bz4, 1);
        if (q4.size() == 0) fail("out4_without_request");
        else begin
          chk("sum4", os4, q4[0]);
          if (!ov4_d) chk("latency4", cyc, d4[0]);
          if (or4) begin
            void'(q4.pop_front());
            void'(d4.pop_front());
            res4++;
          end
        end
      end
      if (iv4 && ir4) begin
        q4.push_back(model(64'(a4), 64'(b4), sub4, 32));
        d4.push_back(cyc + 1 + 4);
      end
      ov4_d <= ov4;
    end
  end

  // Scoreboard for the NWORDS=1 instance
  logic [63:0] q1[$];
  longint      d1[$];
  logic        ov1_d = 1'b0;
  always @(negedge clk) begin
    if (rst1) begin
      chk("rst1_in_ready", ir1, 1);
      chk("rst1_out_valid", ov1, 0);
      chk("rst1_out_sum", os1, 0);
      q1.delete();
      d1.delete();
      ov1_d <= 1'b0;
    end else begin
      chk("ready1_vs_busy", ir1, !bz1);
      if (ov1) begin
        if (q1.size() == 0) fail("out1_without_request");
        else begin
          chk("sum1", os1, q1[0]);
          if (!ov1_d) chk("latency1", cyc, d1[0]);
          if (or1) begin
            void'(q1.pop_front());
            void'(d1.pop_front());
          end
        end
      end
      if (iv1 && ir1) begin
        q1.push_back(model(64'(a1), 64'(b1), sub1, 8));
        d1.push_back(cyc + 1 + 1);
      end
      ov1_d <= ov1;
    end
  end

  function automatic logic rdy(input int d);
    return (d == 4) ? ir4 : ir1;
  endfunction

  function automatic logic vld(input int d);
    return (d == 4) ? ov4 : ov1;
  endfunction

  // Present a request and return just after its accept edge with operands scrambled
  task automatic req(input int d, input logic [31:0] a, input logic [31:0] b, input logic s);
    int  n;
    logic got;
    n = 0;
    got = 1'b0;
    if (d == 4) begin a4 = a; b4 = b; sub4 = s; iv4 = 1'b1; end
    else begin a1 = a[7:0]; b1 = b[7:0]; sub1 = s; iv1 = 1'b1; end
    while (!got && n < 50) begin
      @(negedge clk);
      got = rdy(d);
      n++;
    end
    if (!got) fail("accept_timeout");
    @(posedge clk);
    #1;
    if (d == 4) begin iv4 = 1'b0; a4 = $urandom; b4 = $urandom; sub4 = 1'($urandom); end
    else begin iv1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom); sub1 = 1'($urandom); end
  endtask

  // Wait for a result, hold it for a few cycles, then take it
  task automatic get(input int d, input int hold, output logic [63:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (!vld(d) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!vld(d)) fail("result_timeout");
    v = (d == 4) ? 64'(os4) : 64'(os1);
    repeat (hold) @(negedge clk);
    @(posedge clk);
    #1;
    if (d == 4) or4 = 1'b1; else or1 = 1'b1;
    @(posedge clk);
    #1;
    if (d == 4) or4 = 1'b0; else or1 = 1'b0;
  endtask

  logic [31:0] ta[5] = '{32'h0000_0010, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'hDEAD_BEEF};
  logic [31:0] tb[5] = '{32'h0000_0020, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h0000_BEEF};
  logic        ts[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    logic [63:0] v;
    int          n;
    int          k;
    int          r0;
    longint      prev;

    rst4 = 1'b1; iv4 = 1'b0; sub4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
    rst1 = 1'b1; iv1 = 1'b0; sub1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0;

    chk("model_add_wrap", model(64'hFFFF_FFFF, 64'h1, 1'b0, 32), 64'h1_0000_0000);
    chk("model_sub_borrow", model(64'h3, 64'h5, 1'b1, 32), 64'h0_FFFF_FFFE);
    chk("model_sub8", model(64'h0, 64'h1, 1'b1, 8), 64'h0FF);

    repeat (3) @(posedge clk);
    #1;
    rst4 = 1'b0;
    rst1 = 1'b0;

    // Full carry ripple across all four slices
    req(4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    get(4, 0, v);
    chk("t1_carry_chain", v, 64'h1_0000_0000);

    // Subtract with and without borrow
    req(4, 32'd5, 32'd3, 1'b1);
    get(4, 0, v);
    chk("t2_sub_no_borrow", v, 64'h1_0000_0002);
    req(4, 32'd3, 32'd5, 1'b1);
    get(4, 0, v);
    chk("t2_sub_borrow", v, 64'h0_FFFF_FFFE);

    // Backpressure: result held, stray requests ignored
    req(4, 32'h1234_5678, 32'h1111_1111, 1'b0);
    n = 0;
    @(negedge clk);
    while (!ov4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      chk("t3_hold_sum", os4, 33'h0_2345_6789);
      chk("t3_hold_valid", ov4, 1);
      @(posedge clk);
      #1;
      iv4 = (i % 2 == 0);
      a4 = $urandom;
      b4 = $urandom;
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    @(posedge clk);
    #1;
    or4 = 1'b0;
    chk("t3_valid_dropped", ov4, 0);
    chk("t3_ready_back", ir4, 1);

    // Asynchronous reset in the second RUN cycle
    req(4, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    @(posedge clk);
    #2;
    rst4 = 1'b1;
    #1;
    chk("t4_rst_ready", ir4, 1);
    chk("t4_rst_valid", ov4, 0);
    chk("t4_rst_busy", bz4, 0);
    chk("t4_rst_sum", os4, 0);
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    req(4, 32'd1, 32'd1, 1'b0);
    get(4, 1, v);
    chk("t4_after_reset", v, 64'h0_0000_0002);

    // Single-slice instance
    req(1, 32'hFF, 32'hFF, 1'b0);
    get(1, 0, v);
    chk("t5_add_ff", v, 64'h1FE);
    req(1, 32'h00, 32'h01, 1'b1);
    get(1, 2, v);
    chk("t5_sub_borrow", v, 64'h0FF);

    // Back-to-back with in_valid and out_ready held high
    r0 = res4;
    or4 = 1'b1;
    a4 = ta[0]; b4 = tb[0]; sub4 = ts[0]; iv4 = 1'b1;
    k = 0;
    n = 0;
    prev = 0;
    while (k < 5 && n < 200) begin
      @(negedge clk);
      n++;
      if (iv4 && ir4) begin
        if (k > 0) chk("t6_accept_spacing", cyc - prev, 6);
        prev = cyc;
        k++;
        @(posedge clk);
        #1;
        if (k < 5) begin a4 = ta[k]; b4 = tb[k]; sub4 = ts[k]; end
        else iv4 = 1'b0;
      end
    end
    if (k < 5) fail("t6_accept_timeout");
    iv4 = 1'b0;
    n = 0;
    while (q4.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_result_count", res4 - r0, 5);
    or4 = 1'b0;

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

endmodule

// File: doc/rca_mw_seq.md
Name: rca_mw_seq

Overview:
Multi-word add/subtract sequencer. It reuses one 8-bit ripple-carry add stage over NWORDS byte slices, one slice per clock, and chains the carry in a register. Operands arrive on a valid/ready request channel and results leave on a valid/ready response channel. It sits between a wide-operand producer and consumer in place of a full-width combinational adder, trading latency for area.

Parameters:
NWORDS, 4, number of 8-bit slices per operand (>=1); operand width W = 8*NWORDS

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request (high only in IDLE)
in_sub  input  1  0: a+b, 1: a-b (two's complement: ~b, carry-in 1)
in_a  input  W  operand A
in_b  input  W  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  W+1  result; bit W = final carry-out (for subtract, 1 = no borrow)
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: the clock is clk; reset is asynchronous and active-high. On reset, state=IDLE, in_ready=1, out_valid=0, busy=0, out_sum=0, slice index=0, carry=0, and the operand registers are cleared.
- States:
  - IDLE -> RUN on in_valid & in_ready.
  - RUN -> DONE after slice NWORDS-1 is computed.
  - DONE -> IDLE on out_valid & out_ready.
- Accept edge:
  - Latch in_a.
  - Latch in_b, inverted when in_sub=1.
  - Load carry=in_sub, idx=0.
  - Clear the out_sum register.
- RUN, each cycle:
  - Compute s = a[8*idx+:8] + b'[8*idx+:8] + carry (9-bit result).
  - Write s[7:0] into out_sum[8*idx+:8]; carry <= s[8]; idx <= idx+1.
  - On the last slice, write out_sum[W] <= s[8] and go to DONE.
- Latency: out_valid rises exactly NWORDS cycles after the accept edge. With NWORDS=1 that is one RUN cycle.
- DONE:
  - out_valid=1.
  - out_sum is held stable until the handshake, regardless of out_ready.
  - On the handshake edge, out_valid drops and the state returns to IDLE. in_ready is high from the next cycle, so there is no same-cycle re-accept.
- in_valid, in_a, in_b and in_sub are ignored outside IDLE. Operands may change after the accept edge without affecting the result.
- out_sum outside DONE: shows partial results during RUN. It is only meaningful while out_valid=1.
- Width rules: all arithmetic is unsigned modulo 2^W; the carry-out is reported in bit W. Signed overflow is not computed.
- idx is ceil(log2(NWORDS)) bits wide, minimum 1. It never exceeds NWORDS-1.
- Reset asserted mid-RUN or mid-DONE: the operation is aborted with no output handshake, and all registers take their reset values immediately.

Decomposition:
- Shared package rca_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the SLICE_W=8 constant;
  - an idx-width function (clog2 with minimum 1).
- One natural sub-module, add8_ci: purely combinational 8-bit ripple-carry adder with carry-in, outputs sum[7:0] and co. It is instantiated once inside rca_mw_seq.

Test Plan:
1. NWORDS=4, add 0xFFFFFFFF + 0x00000001 -> out_valid exactly 4 cycles after accept; out_sum=0x1_00000000; in_ready=0 throughout.
2. NWORDS=4, subtract 5 - 3 -> out_sum=0x1_00000002. Then subtract 3 - 5 -> out_sum=0x0_FFFFFFFE.
3. Backpressure:
   - Add 0x12345678 + 0x11111111 with out_ready held low for 6 cycles in DONE.
   - out_sum must stay 0x0_23456789 and out_valid stay 1; in_valid pulses during that window are ignored.
   - After out_ready, in_ready returns the next cycle.
4. Reset pulse in the 2nd RUN cycle -> all outputs read reset values immediately (async). A new request after reset completes normally: 0x00000001 + 0x00000001 -> 0x0_00000002.
5. NWORDS=1: 0xFF + 0xFF -> out_sum=0x1FE, one cycle after accept. Then 0x00 - 0x01 -> 0x0FF.
6. Back-to-back: in_valid held high with new operands and out_ready tied high. The requests are accepted every NWORDS+2 cycles, each result is correct, and no request is lost or duplicated.
